fetch_queue: RTL
================

// Module: fetch_queue
// PURPOSE
//  Prefetch buffer between instruction memory and decode.
//  Each cycle the fetch stage presents ProgCtr plus the combinational ROM word InstIn.
//  This block queues {PC, instruction} pairs in a DEPTH-entry circular FIFO.
//  It presents the oldest pair to decode over a valid/ready handshake, and back-pressures fetch via FetchStall.
//  Flush discards all queued and in-flight words when a jump/branch resolves.
// PARAMETERS
//  DEPTH  4   queue entries; power of 2, >= 2
//  IW     9   instruction width (bits)
//  AW     10  program-counter width (bits)
// PORTS
//  Clk        in   1      clock; all state changes on posedge only
//  Reset      in   1      asynchronous, active-low reset (0 = reset asserted)
//  ProgCtr    in   AW     PC of the word on InstIn this cycle
//  InstIn     in   IW     instruction memory output for ProgCtr
//  FetchValid in   1      1 = ProgCtr/InstIn form a new fetch this cycle
//  Flush      in   1      1 = discard all entries and this cycle's fetch
//  OutReady   in   1      decode accepts head entry this cycle
//  OutValid   out  1      head entry valid
//  InstOut    out  IW     head instruction
//  PcOut      out  AW     PC of head instruction
//  FetchStall out  1      queue full; fetch must hold ProgCtr
//  Count      out  $clog2(DEPTH)+1  current occupancy
// BEHAVIOUR
//  State: storage mem[DEPTH] of {AW+IW}; wr_ptr, rd_ptr ($clog2(DEPTH) bits, wrap modulo DEPTH); count.
//  Reset (Reset==0, async): wr_ptr=rd_ptr=0, count=0; OutValid=0, FetchStall=0, Count=0.
//   InstOut/PcOut read 0 while empty after reset (mem cleared on reset).
//  Derived outputs (combinational from registered state only):
//   OutValid = (count!=0); FetchStall = (count==DEPTH); InstOut/PcOut = mem[rd_ptr]; Count = count.
//  enq = FetchValid & ~FetchStall & ~Flush.
//  deq = OutValid & OutReady & ~Flush.
//  On posedge:
//   Flush=1 -> wr_ptr=rd_ptr=0, count=0; enq/deq suppressed.
//    Entries vanish on the next cycle (OutValid=0).
//   enq  -> mem[wr_ptr]={ProgCtr,InstIn}; wr_ptr++.
//   deq  -> rd_ptr++.
//   count += enq - deq (simultaneous enq+deq: count unchanged).
//  Latency: word enqueued at edge N appears on InstOut after edge N if the queue was empty (1 cycle).
//  Full: enq blocked while count==DEPTH, even if deq in the same cycle.
//   FetchStall is never combinationally dependent on OutReady.
//  Empty: deq impossible (OutValid=0); OutReady ignored.
//  Wrap-around: pointers wrap DEPTH-1 -> 0 with no bubble; FIFO order preserved.
//  Handshake: while OutValid=1 & OutReady=0, InstOut/PcOut hold stable until deq or Flush.
//  FetchValid while FetchStall=1: word dropped here. Fetch is required to hold ProgCtr, so it is re-presented.
//  Reset mid-operation: all contents lost immediately; no partial entry survives.
//  Assertions: count<=DEPTH; no enq when count==DEPTH; no deq when count==0.
// TESTING
//  T1 reset: Reset=0 mid-stream with 3 entries -> OutValid=0, Count=0, FetchStall=0 same cycle; resume clean.
//  T2 fill: OutReady=0, fetch PC 0..5 (InstIn=9'h100+PC)
//   -> Count 1,2,3,4; FetchStall=1 after 4th edge; PCs 4,5 not stored.
//  T3 drain order: from full (PC 0..3), OutReady=1, FetchValid=0
//   -> PcOut 0,1,2,3 on consecutive cycles; then OutValid=0.
//  T4 wrap: continuous FetchValid=1, OutReady=1 for 10 cycles from PC 0x3F8
//   -> Count steady at 1; PcOut 0x3F8..0x3FF,0x000,0x001; no gaps; pointers wrap.
//  T5 flush: Count=3 with Flush=1, FetchValid=1, OutReady=1 same cycle
//   -> next cycle Count=0, OutValid=0, no word dequeued or enqueued.
//  T6 full+deq: Count=4, OutReady=1, FetchValid=1 -> Count=3 after edge (enq blocked); next edge Count=3 (enq+deq).

Source files
------------

// File: rtl/fetch_queue_if.sv
// fetch_queue_if
//   Bundles the fetch-side and decode-side signals of the prefetch queue.
//   slave  : the queue itself (consumes fetch/decode controls, drives head/status)
//   master : the environment (fetch stage and decode stage)
// Signals
//   ProgCtr, InstIn, FetchValid   fetch word and its qualifier
//   Flush                         discard everything queued and in flight
//   OutReady                      decode accepts the head entry
//   OutValid, InstOut, PcOut      head entry presented to decode
//   FetchStall                    queue full, fetch must hold ProgCtr
//   Count                         current occupancy
interface fetch_queue_if #(
    parameter int DEPTH = 4,
    parameter int IW    = 9,
    parameter int AW    = 10
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [AW-1:0] ProgCtr;
    logic [IW-1:0] InstIn;
    logic          FetchValid;
    logic          Flush;
    logic          OutReady;
    logic          OutValid;
    logic [IW-1:0] InstOut;
    logic [AW-1:0] PcOut;
    logic          FetchStall;
    logic [CW-1:0] Count;

    modport slave (
        input  ProgCtr, InstIn, FetchValid, Flush, OutReady,
        output OutValid, InstOut, PcOut, FetchStall, Count
    );

    modport master (
        output ProgCtr, InstIn, FetchValid, Flush, OutReady,
        input  OutValid, InstOut, PcOut, FetchStall, Count
    );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue
//   Prefetch buffer between instruction memory and decode. Queues
//   {PC, instruction} pairs in a DEPTH-entry circular FIFO, presents the
//   oldest pair over a valid/ready handshake and stalls fetch when full.
// Ports
//   Clk    clock, all state changes on posedge
//   Reset  asynchronous active-low reset
//   bus    fetch_queue_if.slave (fetch inputs, decode handshake, status)
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int IW    = 9,
    parameter int AW    = 10
) (
    input  logic         Clk,
    input  logic         Reset,
    fetch_queue_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW+IW-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             full;
    logic             enq;
    logic             deq;

    // Status comes from registered state only, so FetchStall never sees OutReady.
    assign full           = (count == CW'(DEPTH));
    assign bus.OutValid   = (count != '0);
    assign bus.FetchStall = full;
    assign bus.Count      = count;
    assign {bus.PcOut, bus.InstOut} = mem[rd_ptr];

    assign enq = bus.FetchValid & ~full & ~bus.Flush;
    assign deq = bus.OutValid & bus.OutReady & ~bus.Flush;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (bus.Flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) begin
                mem[wr_ptr] <= {bus.ProgCtr, bus.InstIn};
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (deq) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(enq) - CW'(deq);
        end
    end

    a_count_bound : assert property (@(posedge Clk) disable iff (!Reset)
        count <= CW'(DEPTH));
    a_no_enq_full : assert property (@(posedge Clk) disable iff (!Reset)
        !(enq && full));
    a_no_deq_empty : assert property (@(posedge Clk) disable iff (!Reset)
        !(deq && count == '0));
endmodule
